// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO read-burst arbiter.
// Optional feature macro: FIFO_ARB_WDT_EN (burst stall watchdog).
package fifo_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   // Default requester count and matching owner-index width
   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned OWN_W     = $clog2(N_REQ_DEF);

   // Owner index width for n requesters (never zero)
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Optional feature macro: FIFO_ARB_WDT_EN (not used in this file).
module fifo_arb_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N     = N_REQ_DEF,
   parameter int unsigned IDX_W = OWN_W
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [N-1:0] w_rot;

   // Rotate requests so bit 0 is the pointer position, then take the lowest set bit
   always_comb begin
      w_rot    = N'({i_req, i_req} >> i_ptr);
      o_any    = 1'b0;
      o_idx    = '0;
      o_onehot = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            o_any = 1'b1;
            if (int'(i_ptr) + i >= int'(N)) begin
               o_idx = IDX_W'(int'(i_ptr) + i - int'(N));
            end else begin
               o_idx = IDX_W'(int'(i_ptr) + i);
            end
         end
      end
      o_onehot = N'(o_any) << o_idx;
   end

endmodule

// File: rtl/fifo_rd_burst_arb.sv
// Read-side burst scheduler sharing one prefetch FIFO read port among N_REQ consumers.
// Optional feature macro: FIFO_ARB_WDT_EN enables the stall watchdog that aborts hung bursts.
module fifo_rd_burst_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned WDT_CYCLES = 1024
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LEN_W-1:0] req_len,
   output logic [N_REQ-1:0]       gnt,
   input  logic [DATA_W-1:0]      fifo_rd_data,
   input  logic                   fifo_rd_vld,
   output logic                   fifo_rd_en,
   output logic [DATA_W-1:0]      out_data,
   output logic [N_REQ-1:0]       out_vld,
   input  logic [N_REQ-1:0]       out_rdy,
   output logic                   out_last,
   output logic [N_REQ-1:0]       done,
   output logic [N_REQ-1:0]       abort
);

   localparam int unsigned IDX_W = idx_w(N_REQ);

   arb_state_e         r_state;
   logic [N_REQ-1:0]   r_gnt;
   logic [N_REQ-1:0]   r_done;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [LEN_W-1:0]   r_cnt;

   logic [N_REQ-1:0]   w_onehot;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [LEN_W-1:0]   w_len;
   logic               w_rdy;
   logic               w_beat;
   logic               w_wdt_hit;
   logic [IDX_W-1:0]   w_ptr_nxt;

   fifo_arb_rr_pick #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_any    (w_any)
   );

   // Burst length of the requester the picker selected
   always_comb begin
      w_len = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (w_onehot[i]) begin
            w_len = req_len[i*LEN_W +: LEN_W];
         end
      end
   end

   // Owner ready is selected through the one-hot grant, so no index decode is needed
   assign w_rdy     = |(out_rdy & r_gnt);
   assign w_beat    = (r_state == ST_BURST) && fifo_rd_vld && w_rdy;
   assign w_ptr_nxt = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

   // Data path toward consumers; the FIFO is popped only when the owner can take the word
   assign fifo_rd_en = (r_state == ST_BURST) && w_rdy;
   assign out_vld    = (r_state == ST_BURST) ? (r_gnt & {N_REQ{fifo_rd_vld}}) : '0;
   assign out_last   = (r_state == ST_BURST) && (r_cnt == '0);
   assign out_data   = fifo_rd_data;
   assign gnt        = r_gnt;
   assign done       = r_done;

`ifdef FIFO_ARB_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] r_stall;
   logic [N_REQ-1:0] r_abort;

   assign w_wdt_hit = (r_state == ST_BURST) && !w_beat &&
                      (r_stall == WDT_W'(WDT_CYCLES - 1));
   assign abort     = r_abort;

   // Count consecutive beat-less burst cycles
   always_ff @(posedge rd_clk) begin
      if (rd_rst || (r_state != ST_BURST) || w_beat || w_wdt_hit) begin
         r_stall <= '0;
      end else begin
         r_stall <= r_stall + WDT_W'(1);
      end
   end

   // One-cycle abort pulse to the owner whose burst timed out
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_abort <= '0;
      end else begin
         r_abort <= w_wdt_hit ? r_gnt : '0;
      end
   end
`else
   logic [31:0] w_unused_wdt;

   assign w_wdt_hit    = 1'b0;
   assign abort        = '0;
   assign w_unused_wdt = 32'(WDT_CYCLES);
`endif

   // Arbitration FSM, grant, beat counter and round-robin pointer
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_done  <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_BURST;
                  r_gnt   <= w_onehot;
                  r_owner <= w_idx;
                  r_cnt   <= w_len;
               end
            end
            ST_BURST: begin
               if (w_beat && (r_cnt == '0)) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_done  <= r_gnt;
                  r_ptr   <= w_ptr_nxt;
               end else if (w_beat) begin
                  r_cnt <= r_cnt - LEN_W'(1);
               end else if (w_wdt_hit) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_burst_arb.sv
// Directed self-checking bench for fifo_rd_burst_arb.
// Define FIFO_ARB_WDT_EN to also exercise the watchdog abort path.
module tb_fifo_rd_burst_arb;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned WDT    = 16;

   logic                   rd_clk = 1'b0;
   logic                   rd_rst;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*LEN_W-1:0] req_len;
   logic [N_REQ-1:0]       gnt;
   logic [DATA_W-1:0]      fifo_rd_data;
   logic                   fifo_rd_vld;
   logic                   fifo_rd_en;
   logic [DATA_W-1:0]      out_data;
   logic [N_REQ-1:0]       out_vld;
   logic [N_REQ-1:0]       out_rdy;
   logic                   out_last;
   logic [N_REQ-1:0]       done;
   logic [N_REQ-1:0]       abort;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_rd_burst_arb #(
      .N_REQ      (N_REQ),
      .DATA_W     (DATA_W),
      .LEN_W      (LEN_W),
      .WDT_CYCLES (WDT)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .req          (req),
      .req_len      (req_len),
      .gnt          (gnt),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_vld  (fifo_rd_vld),
      .fifo_rd_en   (fifo_rd_en),
      .out_data     (out_data),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_last     (out_last),
      .done         (done),
      .abort        (abort)
   );

   always #5 rd_clk = ~rd_clk;

   // Advance to the next falling edge: inputs set before this are taken at the rising edge between
   task automatic tick();
      @(negedge rd_clk);
   endtask

   task automatic do_reset();
      rd_rst = 1'b1;
      req    = '0;
      tick();
      tick();
      rd_rst = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst = 1'b1; req = '0; req_len = '0; fifo_rd_vld = 1'b1; out_rdy = '1; fifo_rd_data = '0;
      tick(); tick(); tick();
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_init_gnt: got %b exp 0000", gnt); end
      n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_init_done: got %b exp 0000", done); end
      n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_init_rden: got %b exp 0", fifo_rd_en); end
      n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL rst_init_vld: got %b exp 0000", out_vld); end
      rd_rst = 1'b0;
      // start a burst of 8 on requester 1, then reset it after two beats
      req = 4'b0010; req_len[15:8] = 8'd7;
      tick();
      n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rst_pre_gnt: got %b exp 0010", gnt); end
      req = '0;
      tick();
      rd_rst = 1'b1;
      tick();
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_gnt: got %b exp 0000", gnt); end
      n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_done: got %b exp 0000", done); end
      n_checks++; if (abort !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_abort: got %b exp 0000", abort); end
      n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_vld: got %b exp 0000", out_vld); end
      n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rden: got %b exp 0", fifo_rd_en); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b exp 0", out_last); end
      tick(); tick();
      rd_rst = 1'b0;
      tick();
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_after_gnt: got %b exp 0000", gnt); end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100; req_len = '0; req_len[23:16] = 8'd3; fifo_rd_vld = 1'b1; out_rdy = '1;
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_pre_gnt: got %b exp 0000", gnt); end
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b exp 0100", gnt); end
      req = '0;
      for (int b = 0; b < 4; b++) begin
         fifo_rd_data = 16'h5A00 + 16'(b);
         #1;
         n_checks++; if (out_vld !== 4'b0100) begin n_fail++; $display("FAIL single_vld beat %0d: got %b exp 0100", b, out_vld); end
         n_checks++; if (out_last !== (b == 3)) begin n_fail++; $display("FAIL single_last beat %0d: got %b exp %b", b, out_last, (b == 3)); end
         n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rden beat %0d: got %b exp 1", b, fifo_rd_en); end
         n_checks++; if (out_data !== 16'h5A00 + 16'(b)) begin n_fail++; $display("FAIL single_data beat %0d: got %h exp %h", b, out_data, 16'h5A00 + 16'(b)); end
         tick();
      end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_end_gnt: got %b exp 0000", gnt); end
      n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL single_done: got %b exp 0100", done); end
      n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL single_idle_vld: got %b exp 0000", out_vld); end
      tick();
      n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_done_pulse: got %b exp 0000", done); end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g;
      do_reset();
      req = 4'b1111; req_len = '0; fifo_rd_vld = 1'b1; out_rdy = '1;
      for (int g = 0; g < 5; g++) begin
         exp_g = 4'b0001 << (g % 4);
         tick();
         n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rot_gnt %0d: got %b exp %b", g, gnt, exp_g); end
         n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL rot_last %0d: got %b exp 1", g, out_last); end
         tick();
         n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rot_gap %0d: got %b exp 0000", g, gnt); end
         n_checks++; if (done !== exp_g) begin n_fail++; $display("FAIL rot_done %0d: got %b exp %b", g, done, exp_g); end
      end
      req = '0;
   endtask

   task automatic test_stall();
      int  beats = 0, empties = 0, cnt = 7;
      bit  ended = 1'b0, tog = 1'b0, v, r;
      do_reset();
      req = 4'b0010; req_len = '0; req_len[15:8] = 8'd7; fifo_rd_vld = 1'b1; out_rdy = '1;
      tick();
      req = '0;
      for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
         if (beats == 3 && empties < 5) begin v = 1'b0; r = 1'b1; empties++; end
         else if (empties == 5) begin v = 1'b1; r = tog; tog = ~tog; end
         else begin v = 1'b1; r = 1'b1; end
         fifo_rd_vld = v; out_rdy = {2'b11, r, 1'b1};
         #1;
         n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stall_gnt cyc %0d: got %b exp 0010", cyc, gnt); end
         n_checks++; if (out_vld !== (v ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL stall_vld cyc %0d: got %b exp %b", cyc, out_vld, (v ? 4'b0010 : 4'b0000)); end
         n_checks++; if (fifo_rd_en !== r) begin n_fail++; $display("FAIL stall_rden cyc %0d: got %b exp %b", cyc, fifo_rd_en, r); end
         n_checks++; if (out_last !== (cnt == 0)) begin n_fail++; $display("FAIL stall_last cyc %0d: got %b exp %b", cyc, out_last, (cnt == 0)); end
         if (v && r) begin
            beats++;
            if (cnt == 0) ended = 1'b1; else cnt--;
         end
         tick();
      end
      n_checks++; if (!ended) begin n_fail++; $display("FAIL stall_timeout: beats %0d exp 8", beats); end
      n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL stall_done: got %b exp 0010", done); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_end_gnt: got %b exp 0000", gnt); end
      out_rdy = '1;
   endtask

   task automatic test_long();
      do_reset();
      req = 4'b1000; req_len = '0; req_len[31:24] = 8'hFF; fifo_rd_vld = 1'b1; out_rdy = '1;
      tick();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL long_gnt: got %b exp 1000", gnt); end
      req = '0;
      for (int b = 0; b < 256; b++) begin
         #1;
         n_checks++; if (out_last !== (b == 255)) begin n_fail++; $display("FAIL long_last beat %0d: got %b exp %b", b, out_last, (b == 255)); end
         n_checks++; if (out_vld !== 4'b1000) begin n_fail++; $display("FAIL long_vld beat %0d: got %b exp 1000", b, out_vld); end
         tick();
      end
      n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL long_done: got %b exp 1000", done); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL long_end_gnt: got %b exp 0000", gnt); end
   endtask

`ifdef FIFO_ARB_WDT_EN
   task automatic test_watchdog();
      do_reset();
      req = 4'b0101; req_len = '0; req_len[7:0] = 8'd7; fifo_rd_vld = 1'b1; out_rdy = '1;
      tick();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wdt_gnt: got %b exp 0001", gnt); end
      req = 4'b0100;
      tick();
      tick();
      out_rdy = '0;
      for (int s = 0; s < 16; s++) begin
         #1;
         n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wdt_hold_gnt stall %0d: got %b exp 0001", s, gnt); end
         n_checks++; if (abort !== 4'b0000) begin n_fail++; $display("FAIL wdt_early_abort stall %0d: got %b exp 0000", s, abort); end
         tick();
      end
      n_checks++; if (abort !== 4'b0001) begin n_fail++; $display("FAIL wdt_abort: got %b exp 0001", abort); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wdt_abort_gnt: got %b exp 0000", gnt); end
      n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL wdt_done: got %b exp 0000", done); end
      tick();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wdt_next_gnt: got %b exp 0100", gnt); end
      n_checks++; if (abort !== 4'b0000) begin n_fail++; $display("FAIL wdt_abort_pulse: got %b exp 0000", abort); end
      req = '0; out_rdy = '1;
   endtask
`else
   task automatic test_no_watchdog();
      do_reset();
      req = 4'b0001; req_len = '0; req_len[7:0] = 8'd3; fifo_rd_vld = 1'b1; out_rdy = '0;
      tick();
      req = '0;
      for (int s = 0; s < 40; s++) tick();
      #1;
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL nowdt_gnt: got %b exp 0001", gnt); end
      n_checks++; if (abort !== 4'b0000) begin n_fail++; $display("FAIL nowdt_abort: got %b exp 0000", abort); end
      out_rdy = '1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_stall();
      test_long();
`ifdef FIFO_ARB_WDT_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
